// File: rtl/uio_bus_arbiter.sv
// Four-requester round-robin owner of a shared 8-bit bidirectional pad bank,
// with a one-cycle turnaround between owners and a per-grant burst cap.
module uio_bus_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  dir,
    input  logic [31:0] dout,
    output logic [3:0]  gnt,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic [7:0]  rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q,   ptr_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [3:0]  gnt_q,   gnt_d;
    logic [7:0]  rdata_q;

    logic [3:0]  owner_oh;
    logic        burst_done;
    logic        release_own;
    logic [3:0]  cand_release;
    logic [2:0]  pick_idle;
    logic [2:0]  pick_release;
    logic        drive_en;

    // Returns {found, index}; the search starts one past ptr and wraps, so
    // the previous owner is considered last.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign owner_oh     = 4'b0001 << owner_q;
    assign burst_done   = (cnt_q == BURST_LAST);
    assign release_own  = !req[owner_q] || burst_done;
    assign cand_release = burst_done ? (req & ~owner_oh) : req;
    assign pick_idle    = rr_pick(req, ptr_q);
    assign pick_release = rr_pick(cand_release, ptr_q);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (pick_idle[2]) begin
                    state_d = ST_TURN;
                    owner_d = pick_idle[1:0];
                end
            end
            ST_TURN: begin
                state_d = ST_OWN;
                ptr_d   = owner_q;
                cnt_d   = 8'd1;
                gnt_d   = owner_oh;
            end
            ST_OWN: begin
                if (release_own) begin
                    cnt_d = 8'd0;
                    if (pick_release[2]) begin
                        state_d = ST_TURN;
                        owner_d = pick_release[1:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    gnt_d = gnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= 8'd0;
            gnt_q   <= 4'b0000;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rdata_q <= uio_in;
        end
    end

    // Pad drive follows dir live so a direction flip needs no turnaround;
    // it is gated by registered state, so reset drops the pads at once.
    assign drive_en = (state_q == ST_OWN) && dir[owner_q];
    assign uio_oe   = {8{drive_en}};
    assign uio_out  = drive_en ? dout[{owner_q, 3'b000} +: 8] : 8'h00;

    assign gnt   = gnt_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed scenarios plus random traffic on two arbiters (burst cap 8 and 1),
// both checked every cycle against a transaction-level reference model.
module tb_uio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [31:0] dout;
    logic [7:0]  uio_in;

    logic [3:0]  gnt_a,  gnt_b;
    logic [7:0]  out_a,  out_b;
    logic [7:0]  oe_a,   oe_b;
    logic [7:0]  rd_a,   rd_b;
    logic        busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 = idle, 1 = turnaround, 2 = owned.
    int         ms[2];
    int         mw[2];
    int         mp[2];
    int         mc[2];
    int         mb[2] = '{8, 1};
    logic [7:0] mrd;

    always #5 clk = ~clk;

    uio_bus_arbiter #(.MAX_BURST(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .dir(dir), .dout(dout),
        .gnt(gnt_a), .uio_in(uio_in), .uio_out(out_a), .uio_oe(oe_a),
        .rdata(rd_a), .busy(busy_a)
    );

    uio_bus_arbiter #(.MAX_BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .dir(dir), .dout(dout),
        .gnt(gnt_b), .uio_in(uio_in), .uio_out(out_b), .uio_oe(oe_b),
        .rdata(rd_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [3:0] c, input int p);
        for (int i = 1; i <= 4; i++) begin
            if (c[(p + i) % 4]) return (p + i) % 4;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = 0; mw[k] = 0; mp[k] = 3; mc[k] = 0;
        end
        mrd = 8'h00;
    endtask

    task automatic model_step();
        logic [3:0] cand;
        for (int k = 0; k < 2; k++) begin
            case (ms[k])
                0: if (req != 4'b0) begin
                    mw[k] = rr(req, mp[k]);
                    ms[k] = 1;
                end
                1: begin
                    ms[k] = 2; mp[k] = mw[k]; mc[k] = 1;
                end
                default: begin
                    if (!req[mw[k]] || mc[k] == mb[k]) begin
                        cand = req;
                        if (mc[k] == mb[k]) cand[mw[k]] = 1'b0;
                        mc[k] = 0;
                        if (cand != 4'b0) begin
                            mw[k] = rr(cand, mp[k]);
                            ms[k] = 1;
                        end else begin
                            ms[k] = 0;
                        end
                    end else begin
                        mc[k]++;
                    end
                end
            endcase
        end
        mrd = uio_in;
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        logic       drv;
        logic [7:0] eo;
        for (int k = 0; k < 2; k++) begin
            eg  = (ms[k] == 2) ? (4'b0001 << mw[k]) : 4'b0000;
            drv = (ms[k] == 2) && dir[mw[k]];
            eo  = drv ? dout[mw[k]*8 +: 8] : 8'h00;
            chk($sformatf("gnt%0d", k),   (k == 0) ? gnt_a  : gnt_b,  eg);
            chk($sformatf("oe%0d", k),    (k == 0) ? oe_a   : oe_b,   drv ? 8'hFF : 8'h00);
            chk($sformatf("out%0d", k),   (k == 0) ? out_a  : out_b,  eo);
            chk($sformatf("busy%0d", k),  (k == 0) ? busy_a : busy_b, ms[k] != 0);
            chk($sformatf("rdata%0d", k), (k == 0) ? rd_a   : rd_b,   mrd);
        end
    endtask

    // Entered just after a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt",  {gnt_a, gnt_b}, 8'h00);
        chk("rst_oe",   {oe_a, oe_b},   16'h0000);
        chk("rst_out",  {out_a, out_b}, 16'h0000);
        chk("rst_rd",   {rd_a, rd_b},   16'h0000);
        chk("rst_busy", {busy_a, busy_b}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        req = 4'b0; dir = 4'b0; dout = 32'h0; uio_in = 8'h0;
        do_reset();

        // Requester 0 wins first and drives its byte after the turnaround.
        req = 4'b0101; dir = 4'b0001; dout = 32'h1122_33A5;
        cycle();
        chk("s1_turn_busy", busy_a, 1'b1);
        chk("s1_turn_oe",   oe_a,   8'h00);
        cycle();
        chk("s1_gnt", gnt_a, 4'b0001);
        chk("s1_oe",  oe_a,  8'hFF);
        chk("s1_out", out_a, 8'hA5);
        // Direction flip takes effect without a turnaround.
        dir = 4'b0000; #1;
        chk("s1_dirflip_oe", oe_a, 8'h00);
        chk("s1_dirflip_gnt", gnt_a, 4'b0001);
        cycle();

        // Full contention: 0,1,2,3,0 in 8-cycle bursts separated by TURN.
        do_reset();
        req = 4'b1111; dir = 4'b1111; dout = 32'hDDCC_BBAA;
        for (int t = 0; t < 46; t++) begin
            #1;
            chk($sformatf("rot_t%0d", t), gnt_a,
                (t < 2) ? 4'b0 : (((t - 2) % 9 == 8) ? 4'b0 : (4'b0001 << (((t - 2) / 9) % 4))));
            cycle();
        end

        // Owner 2 samples the pads; rdata lags uio_in by one edge.
        do_reset();
        req = 4'b0100; dir = 4'b0000; uio_in = 8'h3C;
        cycle();
        cycle();
        chk("s3_gnt", gnt_a, 4'b0100);
        chk("s3_oe",  oe_a,  8'h00);
        chk("s3_rd",  rd_a,  8'h3C);
        uio_in = 8'h5A; #1;
        chk("s3_rd_hold", rd_a, 8'h3C);
        cycle();
        chk("s3_rd_next", rd_a, 8'h5A);

        // Owner 1 drops its request after three owned cycles.
        do_reset();
        req = 4'b0010; dir = 4'b0010;
        cycle(); cycle();
        cycle(); cycle(); cycle();
        req = 4'b0000; #1;
        chk("s4_last_gnt", gnt_a, 4'b0010);
        cycle();
        chk("s4_gnt",  gnt_a,  4'b0000);
        chk("s4_busy", busy_a, 1'b0);

        // Reset in the middle of an owned, driving cycle frees the pads at once.
        do_reset();
        req = 4'b0001; dir = 4'b0001; dout = 32'h0000_00C3;
        cycle(); cycle();
        chk("s5_oe_before", oe_a, 8'hFF);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s5_oe_async",  oe_a,  8'h00);
        chk("s5_gnt_async", gnt_a, 4'b0000);
        chk("s5_out_async", out_a, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Burst cap of one alternates between the two requesters.
        req = 4'b0011; dir = 4'b0000;
        for (int t = 0; t < 10; t++) begin
            #1;
            chk($sformatf("mb1_t%0d", t), gnt_b,
                (t < 2 || t % 2 == 1) ? 4'b0 : (4'b0001 << (((t - 2) / 2) % 2)));
            cycle();
        end

        // Random traffic against the model on both instances.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) dir = 4'($urandom_range(0, 15));
            dout   = $urandom;
            uio_in = 8'($urandom_range(0, 255));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
